// File: rtl/saradc_cdac_dummy_seq_if.sv
// Bus between the SAR controller side and the dummy-CDAC sequencer.
//   master : SAR controller / bench  drives MODE, GEN, SOC, STEP, DEC
//   slave  : saradc_cdac_dummy_seq   drives CRI/CRIB, CRH/CRHB, CRL/CRLB, BUSY, DONE
// NG sets the width of the per-group signals.
interface saradc_cdac_dummy_seq_if #(
  parameter int NG = 4
);
  logic [1:0]    MODE;
  logic [NG-1:0] GEN;
  logic          SOC;
  logic          STEP;
  logic          DEC;
  logic [NG-1:0] CRI, CRIB;
  logic [NG-1:0] CRH, CRHB;
  logic [NG-1:0] CRL, CRLB;
  logic          BUSY;
  logic          DONE;

  modport master (
    output MODE, GEN, SOC, STEP, DEC,
    input  CRI, CRIB, CRH, CRHB, CRL, CRLB, BUSY, DONE
  );

  modport slave (
    input  MODE, GEN, SOC, STEP, DEC,
    output CRI, CRIB, CRH, CRHB, CRL, CRLB, BUSY, DONE
  );
endinterface

// File: rtl/saradc_cdac_dummy_seq.sv
// Sequenced dummy-CDAC driver. Runs NG dummy groups through the same
// sample / break / convert cadence as the active DAC so they draw matched
// switching charge.
//
// Ports:
//   CLK  - block clock
//   RST  - synchronous, active-high reset
//   bus  - saradc_cdac_dummy_seq_if.slave
//          in : MODE (0 STATIC, 1 MIRROR, 2 PRBS, 3 = STATIC), GEN, SOC, STEP, DEC
//          out: CRI/CRIB, CRH/CRHB, CRL/CRLB (per group), BUSY, DONE
//
// Build option: define SARADC_CDAC_DUMMY_PRBS_EN to build the 16-bit LFSR
// and PRBS mode. Without it, MODE=2 behaves as STATIC.
module saradc_cdac_dummy_seq #(
  parameter int          NG        = 4,
  parameter int          NBITS     = 8,
  parameter int          NSAMP     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                    CLK,
  input logic                    RST,
  saradc_cdac_dummy_seq_if.slave bus
);

  localparam int CW = $clog2(NBITS + 1);
  localparam int SW = (NSAMP > 1) ? $clog2(NSAMP) : 1;

  localparam logic [1:0] M_MIRROR = 2'd1;
  localparam logic [1:0] M_PRBS   = 2'd2;

  typedef enum logic [1:0] {IDLE, SAMPLE, BRK, CONV} state_t;

  // A zero seed would lock the PRBS at all-zeros; no hardware is built here,
  // the branch only exists so a bad seed stands out at elaboration review.
  if (LFSR_SEED == 16'h0000) begin : g_seed_zero_locks_prbs
  end

  // Groups that actually switch: enabled and in a switching mode.
  function automatic logic [NG-1:0] act_mask(input logic [1:0] m, input logic [NG-1:0] g);
`ifdef SARADC_CDAC_DUMMY_PRBS_EN
    return (m == M_MIRROR || m == M_PRBS) ? g : '0;
`else
    return (m == M_MIRROR) ? g : '0;
`endif
  endfunction

  state_t         state, nstate;
  logic [1:0]     mode_q, nmode;
  logic [NG-1:0]  gen_q, ngen;
  logic [SW-1:0]  scnt, nscnt;
  logic [CW-1:0]  stepcnt, nstep;
  logic [NG-1:0]  lvl, nlvl;     // per-group level: 1 = CRH, 0 = CRL
  logic [NG-1:0]  brk, nbrk;     // per-group break cycle in progress
  logic [NG-1:0]  tgt_q, ntgt;   // level to take once the break ends
  logic [NG-1:0]  act, tgt, chg;
  logic [NG-1:0]  ncri, ncrh, ncrl;
  logic           nbusy, ndone;
  logic [NG-1:0]  cri_q, crib_q, crh_q, crhb_q, crl_q, crlb_q;
  logic           busy_q, done_q;
`ifdef SARADC_CDAC_DUMMY_PRBS_EN
  logic [15:0]    lfsr, nlfsr;
`endif

  assign act = act_mask(mode_q, gen_q);

  always_comb begin
    nstate = state;
    nmode  = mode_q;
    ngen   = gen_q;
    nscnt  = scnt;
    nstep  = stepcnt;
    nlvl   = lvl;
    nbrk   = brk;
    ntgt   = tgt_q;
    ncri   = '0;
    ncrh   = '0;
    ncrl   = '0;
    nbusy  = busy_q;
    ndone  = 1'b0;
    tgt    = {NG{bus.DEC}};
    chg    = '0;
`ifdef SARADC_CDAC_DUMMY_PRBS_EN
    nlfsr  = lfsr;
    if (mode_q == M_PRBS) tgt = lfsr[NG-1:0];
`endif
    case (state)
      IDLE: begin
        nbusy = 1'b0;
        if (bus.SOC) begin
          nstate = SAMPLE;
          nmode  = bus.MODE;
          ngen   = bus.GEN;
          nscnt  = '0;
          nstep  = '0;
          nbrk   = '0;
          nbusy  = 1'b1;
          ncri   = act_mask(bus.MODE, bus.GEN);
        end
      end
      SAMPLE: begin
        if (scnt == SW'(NSAMP - 1)) begin
          nstate = BRK;
        end else begin
          nscnt = scnt + SW'(1);
          ncri  = act;
        end
      end
      BRK: begin
        // Conversion always opens from the high reference.
        nstate = CONV;
        nlvl   = '1;
        nbrk   = '0;
        ncrh   = act;
      end
      CONV: begin
        if (stepcnt == CW'(NBITS)) begin
          // Final pattern has been shown for its one cycle.
          nstate = IDLE;
          nbusy  = 1'b0;
          ndone  = 1'b1;
        end else begin
          if (|brk) begin
            // Break ends: breaking groups take the new level; steps are
            // not accepted on this cycle.
            nlvl = (lvl & ~brk) | (tgt_q & brk);
            nbrk = '0;
          end else if (bus.STEP) begin
            chg   = (tgt ^ lvl) & act;
            nbrk  = chg;
            ntgt  = tgt;
            nstep = stepcnt + CW'(1);
`ifdef SARADC_CDAC_DUMMY_PRBS_EN
            if (mode_q == M_PRBS)
              nlfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
          end
          ncrh = nlvl & act & ~nbrk;
          ncrl = ~nlvl & act & ~nbrk;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      mode_q  <= '0;
      gen_q   <= '0;
      scnt    <= '0;
      stepcnt <= '0;
      lvl     <= '0;
      brk     <= '0;
      tgt_q   <= '0;
      cri_q   <= '0;
      crh_q   <= '0;
      crl_q   <= '0;
      crib_q  <= '1;
      crhb_q  <= '1;
      crlb_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SARADC_CDAC_DUMMY_PRBS_EN
      lfsr    <= LFSR_SEED;
`endif
    end else begin
      state   <= nstate;
      mode_q  <= nmode;
      gen_q   <= ngen;
      scnt    <= nscnt;
      stepcnt <= nstep;
      lvl     <= nlvl;
      brk     <= nbrk;
      tgt_q   <= ntgt;
      cri_q   <= ncri;
      crh_q   <= ncrh;
      crl_q   <= ncrl;
      // Complements get their own flops so both rails switch on the edge.
      crib_q  <= ~ncri;
      crhb_q  <= ~ncrh;
      crlb_q  <= ~ncrl;
      busy_q  <= nbusy;
      done_q  <= ndone;
`ifdef SARADC_CDAC_DUMMY_PRBS_EN
      lfsr    <= nlfsr;
`endif
    end
  end

  assign bus.CRI  = cri_q;
  assign bus.CRIB = crib_q;
  assign bus.CRH  = crh_q;
  assign bus.CRHB = crhb_q;
  assign bus.CRL  = crl_q;
  assign bus.CRLB = crlb_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_saradc_cdac_dummy_seq.sv
// Scoreboard bench for saradc_cdac_dummy_seq (NG=4, NBITS=8, NSAMP=4).
// Stimulus tasks push the hand-computed per-cycle output expected for each
// cycle of a scenario; a negedge monitor pops and compares, and also checks
// every cycle that each xB rail is the inverse of its partner.
module tb_saradc_cdac_dummy_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   ecyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] cri, crh, crl;
    logic       busy, done;
  } exp_t;

  exp_t q[$];
  exp_t me;

  saradc_cdac_dummy_seq_if #(.NG(4)) bus ();

  saradc_cdac_dummy_seq #(
    .NG(4), .NBITS(8), .NSAMP(4), .LFSR_SEED(16'hACE1)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rail_inverse_i", bus.CRIB, ~bus.CRI);
      chk("rail_inverse_h", bus.CRHB, ~bus.CRH);
      chk("rail_inverse_l", bus.CRLB, ~bus.CRL);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        me = q.pop_front();
        if (me.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_entry cyc=%0d got=none want=%0d", cyc, me.cyc);
        end else begin
          chk("cri",  bus.CRI, me.cri);
          chk("crh",  bus.CRH, me.crh);
          chk("crl",  bus.CRL, me.crl);
          chk("busy", {3'b000, bus.BUSY}, {3'b000, me.busy});
          chk("done", {3'b000, bus.DONE}, {3'b000, me.done});
        end
      end
    end
  end

  task automatic expn(input int n, input logic [3:0] ci, input logic [3:0] ch,
                      input logic [3:0] cl, input logic b, input logic d);
    for (int i = 0; i < n; i++) begin
      q.push_back('{cyc: ecyc, cri: ci, crh: ch, crl: cl, busy: b, done: d});
      ecyc++;
    end
  endtask

  task automatic cyc_in(input logic s, input logic st, input logic d);
    bus.SOC  = s;
    bus.STEP = st;
    bus.DEC  = d;
    @(posedge clk);
    #1;
  endtask

  // MIRROR, GEN=1011, eight DEC=1 steps: no breaks, DONE 2 cycles after the
  // 8th step. Also a STEP during SAMPLE and an SOC (with other MODE/GEN)
  // mid-conversion, both of which must be ignored.
  task automatic conv_mirror_hold();
    bus.MODE = 2'd1;
    bus.GEN  = 4'b1011;
    ecyc = cyc;
    expn(1,  4'h0,    4'h0,    4'h0, 1'b0, 1'b0);
    expn(4,  4'b1011, 4'h0,    4'h0, 1'b1, 1'b0);
    expn(1,  4'h0,    4'h0,    4'h0, 1'b1, 1'b0);
    expn(16, 4'h0,    4'b1011, 4'h0, 1'b1, 1'b0);
    expn(1,  4'h0,    4'h0,    4'h0, 1'b0, 1'b1);
    expn(2,  4'h0,    4'h0,    4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 25; k++) begin
      if (k == 10) begin bus.GEN = 4'hF; bus.MODE = 2'd2; end
      if (k == 11) begin bus.GEN = 4'b1011; bus.MODE = 2'd1; end
      cyc_in(k == 0 || k == 10, k == 3 || (k >= 6 && k <= 20 && k % 2 == 0), k >= 3);
    end
  endtask

  // MIRROR, DEC=0 step: break then CRL=GEN; a STEP during the break is
  // ignored and not counted; last step flips back to high and its break is
  // the final pattern.
  task automatic conv_mirror_flip();
    bus.MODE = 2'd1;
    bus.GEN  = 4'b1011;
    ecyc = cyc;
    expn(1,  4'h0,    4'h0,    4'h0,    1'b0, 1'b0);
    expn(4,  4'b1011, 4'h0,    4'h0,    1'b1, 1'b0);
    expn(1,  4'h0,    4'h0,    4'h0,    1'b1, 1'b0);
    expn(1,  4'h0,    4'b1011, 4'h0,    1'b1, 1'b0);
    expn(1,  4'h0,    4'h0,    4'h0,    1'b1, 1'b0);
    expn(13, 4'h0,    4'h0,    4'b1011, 1'b1, 1'b0);
    expn(1,  4'h0,    4'h0,    4'h0,    1'b1, 1'b0);
    expn(1,  4'h0,    4'h0,    4'h0,    1'b0, 1'b1);
    expn(2,  4'h0,    4'h0,    4'h0,    1'b0, 1'b0);
    for (int k = 0; k < 25; k++)
      cyc_in(k == 0, k == 6 || k == 7 || (k >= 8 && k <= 20 && k % 2 == 0), k == 7 || k == 20);
  endtask

  // PRBS, GEN=F: two steps from the seed, then RST (together with SOC)
  // three cycles into CONV.
  task automatic conv_prbs_abort();
    bus.MODE = 2'd2;
    bus.GEN  = 4'hF;
    ecyc = cyc;
    expn(1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef SARADC_CDAC_DUMMY_PRBS_EN
    expn(4, 4'hF, 4'h0,    4'h0,    1'b1, 1'b0);
    expn(1, 4'h0, 4'h0,    4'h0,    1'b1, 1'b0);
    expn(1, 4'h0, 4'hF,    4'h0,    1'b1, 1'b0);
    expn(1, 4'h0, 4'b0001, 4'h0,    1'b1, 1'b0);
    expn(1, 4'h0, 4'b0001, 4'b1110, 1'b1, 1'b0);
    expn(1, 4'h0, 4'b0001, 4'b1100, 1'b1, 1'b0);
`else
    expn(9, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
`endif
    expn(3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) begin
      rst = (k == 9);
      cyc_in(k == 0 || k == 9, k == 6 || k == 8, 1'b1);
    end
  endtask

  // STATIC: everything disabled but BUSY/DONE still follow the step count.
  task automatic conv_static();
    bus.MODE = 2'd0;
    bus.GEN  = 4'hF;
    ecyc = cyc;
    expn(1,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    expn(21, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    expn(1,  4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    expn(2,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 25; k++)
      cyc_in(k == 0, k >= 6 && k <= 20 && k % 2 == 0, k % 4 == 0);
  endtask

  initial begin
    bus.MODE = 2'd0;
    bus.GEN  = 4'h0;
    bus.SOC  = 1'b0;
    bus.STEP = 1'b0;
    bus.DEC  = 1'b0;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state and ten idle cycles.
    ecyc = cyc;
    expn(10, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (10) cyc_in(1'b0, 1'b0, 1'b0);

    conv_mirror_hold();
    conv_mirror_flip();
    conv_prbs_abort();
    conv_prbs_abort();   // LFSR must restart from the seed after reset
    conv_static();

    cyc_in(1'b0, 1'b0, 1'b0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
